// File: rtl/shift_register_seq_if.sv
// Operand-register bus: instruction handshake in, registered word/status out.
// SHIFT_SERIAL_IN_EN adds the ser_in / ser_valid serial pair.
interface shift_register_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [2:0]       instruction;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic             carry_out;
`ifdef SHIFT_SERIAL_IN_EN
  logic             ser_in;
  logic             ser_valid;

  modport master (
    output start, instruction, amount, data_in, ser_in,
    input  data_out, busy, done, carry_out, ser_valid
  );
  modport slave (
    input  start, instruction, amount, data_in, ser_in,
    output data_out, busy, done, carry_out, ser_valid
  );
`else
  modport master (
    output start, instruction, amount, data_in,
    input  data_out, busy, done, carry_out
  );
  modport slave (
    input  start, instruction, amount, data_in,
    output data_out, busy, done, carry_out
  );
`endif
endinterface

// File: rtl/shift_register_seq.sv
// WIDTH-bit operand register: load/clear plus shifts and rotates stepped one bit per clock.
// Optional SHIFT_SERIAL_IN_EN: serial fill for logical shifts and a ser_valid strobe.
module shift_register_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input logic                 clock,
  input logic                 reset_n,
  shift_register_seq_if.slave bus
);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_SHIFTR = 3'b010;
  localparam logic [2:0] OP_SHIFTL = 3'b011;
  localparam logic [2:0] OP_CLEAR  = 3'b100;
  localparam logic [2:0] OP_ROTR   = 3'b101;
  localparam logic [2:0] OP_ROTL   = 3'b110;
  localparam logic [2:0] OP_ASHR   = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_done;
  logic             r_carry;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_ser_valid;

  logic             w_accept;
  logic             w_is_shift;
  logic [AMT_W-1:0] w_k;
  logic [2:0]       w_step_op;
  logic             w_fill;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;

  function automatic logic f_is_shift(input logic [2:0] op);
    return (op == OP_SHIFTR) || (op == OP_SHIFTL) || (op == OP_ROTR) ||
           (op == OP_ROTL)   || (op == OP_ASHR);
  endfunction

  // One-bit step; returns {bit leaving the word, new word}.
  function automatic logic [WIDTH:0] f_step(input logic [2:0] op,
                                            input logic [WIDTH-1:0] d,
                                            input logic fill);
    logic [WIDTH:0] res;
    res = {1'b0, d};
    case (op)
      OP_SHIFTR: res = {d[0], fill, d[WIDTH-1:1]};
      OP_SHIFTL: res = {d[WIDTH-1], d[WIDTH-2:0], fill};
      OP_ROTR:   res = {d[0], d[0], d[WIDTH-1:1]};
      OP_ROTL:   res = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_ASHR:   res = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default:   res = {1'b0, d};
    endcase
    return res;
  endfunction

  always_comb begin
    w_accept   = bus.start && (r_state == ST_IDLE);
    w_is_shift = f_is_shift(bus.instruction);
    w_k        = (bus.amount > W_AMT) ? W_AMT : bus.amount;
    // The acceptance edge already performs step 1, so it uses the live opcode.
    w_step_op  = (r_state == ST_RUN) ? r_op : bus.instruction;
`ifdef SHIFT_SERIAL_IN_EN
    w_fill     = bus.ser_in;
`else
    w_fill     = 1'b0;
`endif
    {w_step_carry, w_step_data} = f_step(w_step_op, r_data, w_fill);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_op        <= OP_HOLD;
      r_ser_valid <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_ser_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= bus.instruction;
            if (w_is_shift && (w_k != '0)) begin
              r_data      <= w_step_data;
              r_carry     <= w_step_carry;
              r_cnt       <= w_k - 1'b1;
              r_ser_valid <= 1'b1;
              if (w_k == AMT_W'(1)) begin
                r_done <= 1'b1;
              end else begin
                r_state <= ST_RUN;
              end
            end else begin
              r_done <= 1'b1;
              case (bus.instruction)
                OP_LOAD: r_data <= bus.data_in;
                OP_CLEAR: begin
                  r_data  <= '0;
                  r_carry <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        ST_RUN: begin
          r_data      <= w_step_data;
          r_carry     <= w_step_carry;
          r_cnt       <= r_cnt - 1'b1;
          r_ser_valid <= 1'b1;
          if (r_cnt == AMT_W'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out  = r_data;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = r_done;
  assign bus.carry_out = r_carry;
`ifdef SHIFT_SERIAL_IN_EN
  assign bus.ser_valid = r_ser_valid;
`endif

endmodule

// File: tb/tb_shift_register_seq.sv
// Scoreboard bench for shift_register_seq: random instructions checked against an arithmetic model.
module tb_shift_register_seq;
  localparam int W  = 8;
  localparam int AW = $clog2(W + 1);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  shift_register_seq_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  shift_register_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    int unsigned  due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int unsigned  cyc = 0;
  logic [W-1:0] m_data = '0;
  logic         m_carry = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

`ifdef SHIFT_SERIAL_IN_EN
  initial bus.ser_in = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-operation model: result of k shifts computed in one go.
  task automatic model(input logic [2:0] op, input int amt, input logic [W-1:0] din,
                       output int lat);
    int k;
    k = (amt > W) ? W : amt;
    lat = 1;
    case (op)
      3'd1: m_data = din;
      3'd4: begin m_data = '0; m_carry = 1'b0; end
      3'd2, 3'd3, 3'd5, 3'd6, 3'd7: begin
        if (k > 0) begin
          lat = k;
          case (op)
            3'd2: begin m_carry = m_data[k-1]; m_data = m_data >> k; end
            3'd3: begin m_carry = m_data[W-k]; m_data = m_data << k; end
            3'd5: begin m_carry = m_data[k-1]; m_data = (m_data >> k) | (m_data << (W - k)); end
            3'd6: begin m_carry = m_data[W-k]; m_data = (m_data << k) | (m_data >> (W - k)); end
            default: begin m_carry = m_data[k-1]; m_data = $signed(m_data) >>> k; end
          endcase
        end
      end
      default: ;
    endcase
  endtask

  // Monitor: pops on every done pulse, flags missing or unexpected completions.
  always @(negedge clock) begin
    exp_t e;
    #1;
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cyc=%0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_data", bus.data_out, e.data);
        check("done_carry", bus.carry_out, e.carry);
        check("done_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      check("done_missing", 0, 1);
    end
  end

  // Called in the low phase of a cycle; returns in the low phase of the done cycle.
  task automatic issue(input logic [2:0] op, input int amt, input logic [W-1:0] din);
    int lat;
    int unsigned acc;
    int n;
    bus.instruction = op;
    bus.amount      = AW'(amt);
    bus.data_in     = din;
    bus.start       = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    acc = cyc;
    model(op, amt, din, lat);
    sb.push_back('{m_data, m_carry, acc + lat - 1});
    check("busy_after_accept", bus.busy, (lat >= 2));
    check("done_after_accept", bus.done, (lat == 1));
    n = 0;
    forever begin
      @(negedge clock);
      #2;
      if (sb.size() == 0) break;
      n++;
      if (n > 40) begin
        check("done_timeout", 0, 1);
        sb.delete();
        break;
      end
      // Junk starts only where busy is still 1 at the next edge.
      if ((cyc + 2 <= acc + lat) && ($urandom_range(0, 1) == 1)) begin
        bus.start       = 1'b1;
        bus.instruction = 3'($urandom);
        bus.amount      = AW'($urandom);
        bus.data_in     = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int lat;
    int unsigned acc;
    logic [2:0] op;
    bus.start = 1'b0;
    bus.instruction = '0;
    bus.amount = '0;
    bus.data_in = '0;

    repeat (2) @(negedge clock);
    check("rst_data", bus.data_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_carry", bus.carry_out, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    check("idle_data", bus.data_out, 0);
    check("idle_done", bus.done, 0);

    issue(3'd1, 0, 8'hA5);
    check("load_data", bus.data_out, 8'hA5);

    bus.instruction = 3'd3;
    bus.amount = AW'(3);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    acc = cyc;
    model(3'd3, 3, '0, lat);
    sb.push_back('{m_data, m_carry, acc + 2});
    check("shl_step1", bus.data_out, 8'h4A);
    check("shl_busy1", bus.busy, 1);
    @(posedge clock);
    #1;
    check("shl_step2", bus.data_out, 8'h94);
    check("shl_busy2", bus.busy, 1);
    @(posedge clock);
    #1;
    check("shl_step3", bus.data_out, 8'h28);
    check("shl_busy3", bus.busy, 0);
    check("shl_done", bus.done, 1);
    check("shl_carry", bus.carry_out, 1);
    @(negedge clock);
    #2;

    issue(3'd1, 0, 8'h90);
    issue(3'd7, 2, '0);
    check("ashr_data", bus.data_out, 8'hE4);
    check("ashr_carry", bus.carry_out, 0);
    issue(3'd1, 0, 8'h3C);
    issue(3'd5, 9, '0);
    check("rotr9_data", bus.data_out, 8'h3C);

    issue(3'd1, 0, 8'h81);
    bus.instruction = 3'd2;
    bus.amount = AW'(5);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    @(negedge clock);
    bus.instruction = 3'd1;
    bus.data_in = 8'hFF;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check("ignored_load", bus.data_out, 8'h20);
    @(posedge clock);
    #1;
    check("shr_step3", bus.data_out, 8'h10);
    reset_n = 1'b0;
    #1;
    check("midrst_data", bus.data_out, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_carry", bus.carry_out, 0);
    @(negedge clock);
    reset_n = 1'b1;
    m_data = '0;
    m_carry = 1'b0;
    repeat (8) @(negedge clock);
    #2;
    check("post_rst_busy", bus.busy, 0);

    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom);
      issue(op, $urandom_range(0, 15), W'($urandom));
    end

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
